// File: rtl/falling_block.sv
// Falling-block producer for the stack catch interface: spawns one block at a time,
// drops it on a slow tick, and tracks score, misses and end of game.
module falling_block #(
  parameter int unsigned TICK_COUNT  = 200000,
  parameter int unsigned FALL_STEP   = 1,
  parameter int unsigned SPAWN_TICKS = 64,
  parameter int unsigned FLOOR_Y     = 480,
  parameter int unsigned PARK_X      = 1023,
  parameter int unsigned MAX_X       = 490,
  parameter int unsigned MISS_LIMIT  = 3,
  parameter int unsigned MAX_LEVELS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       collision,
  input  logic [9:0] height,
  output logic [9:0] fall_x,
  output logic [9:0] fall_y,
  output logic [1:0] fall_color,
  output logic       active,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  typedef enum logic [1:0] {S_WAIT, S_FALLING, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   countdown;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [8:0]    raw_x;
  logic [9:0]    spawn_x;
  logic [1:0]    spawn_color;
  logic [10:0]   y_next;

  assign tick = !pause && (tick_cnt == CW'(TICK_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick_cnt <= '0;
    else if (!pause)
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Taps 16,14,13,11; free-runs regardless of pause so spawns stay unpredictable.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (lfsr_next == '0)
      lfsr_next = 16'hACE1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else
      lfsr <= lfsr_next;
  end

  always_comb begin
    raw_x       = lfsr[8:0];
    spawn_x     = (raw_x > 9'(MAX_X)) ? {1'b0, raw_x - 9'd256} : {1'b0, raw_x};
    spawn_color = (lfsr[10:9] == 2'b00) ? 2'b01 : lfsr[10:9];
    y_next      = {1'b0, fall_y} + 11'(FALL_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT;
      fall_x     <= 10'(PARK_X);
      fall_y     <= '0;
      fall_color <= '0;
      active     <= 1'b0;
      score      <= '0;
      misses     <= '0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      countdown  <= 16'(SPAWN_TICKS);
    end else begin
      case (state)
        S_WAIT: begin
          if (height >= 10'(MAX_LEVELS)) begin
            state     <= S_DONE;
            game_over <= 1'b1;
            win       <= 1'b1;
          // Spawn on the tick that would take the countdown to zero.
          end else if (countdown == '0 || (tick && countdown == 16'd1)) begin
            state      <= S_FALLING;
            fall_y     <= '0;
            fall_x     <= spawn_x;
            fall_color <= spawn_color;
            active     <= 1'b1;
            countdown  <= '0;
          end else if (tick) begin
            countdown <= countdown - 16'd1;
          end
        end
        S_FALLING: begin
          if (collision) begin
            if (score != '1)
              score <= score + 8'd1;
            fall_x    <= 10'(PARK_X);
            active    <= 1'b0;
            countdown <= 16'(SPAWN_TICKS);
            state     <= S_WAIT;
          end else if (tick) begin
            if (y_next >= 11'(FLOOR_Y)) begin
              misses <= misses + 2'd1;
              fall_x <= 10'(PARK_X);
              active <= 1'b0;
              if (misses + 2'd1 == 2'(MISS_LIMIT)) begin
                state     <= S_DONE;
                game_over <= 1'b1;
              end else begin
                countdown <= 16'(SPAWN_TICKS);
                state     <= S_WAIT;
              end
            end else begin
              fall_y <= y_next[9:0];
            end
          end
        end
        S_DONE: begin
          game_over <= 1'b1;
          fall_x    <= 10'(PARK_X);
          active    <= 1'b0;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_falling_block.sv
// Self-checking bench for falling_block with a short tick (4 clk) and 2-tick spawn delay.
module tb_falling_block;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause;
  logic       collision;
  logic [9:0] height;
  logic [9:0] fall_x;
  logic [9:0] fall_y;
  logic [1:0] fall_color;
  logic       active;
  logic [7:0] score;
  logic [1:0] misses;
  logic       game_over;
  logic       win;

  int compared   = 0;
  int mismatched = 0;
  int exp_y_q[$];

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  falling_block #(.TICK_COUNT(4), .SPAWN_TICKS(2)) dut (
    .clk(clk), .rst(rst), .pause(pause), .collision(collision), .height(height),
    .fall_x(fall_x), .fall_y(fall_y), .fall_color(fall_color), .active(active),
    .score(score), .misses(misses), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value the DUT saw before the latest edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic logic [9:0] exp_x(input logic [15:0] p);
    logic [8:0] r;
    r = p[8:0];
    return (r > 9'd490) ? {1'b0, r - 9'd256} : {1'b0, r};
  endfunction

  function automatic logic [1:0] exp_c(input logic [15:0] p);
    return (p[10:9] == 2'b00) ? 2'b01 : p[10:9];
  endfunction

  task automatic wait_y(input int target, input int budget);
    int n = 0;
    while (fall_y !== 10'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (fall_y !== 10'(target)) begin
      mismatched++;
      $display("FAIL wait_y: fall_y=%0d never reached %0d", fall_y, target);
    end
  endtask

  task automatic wait_active(input int budget);
    int n = 0;
    while (active !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (active !== 1'b1) begin
      mismatched++;
      $display("FAIL wait_active: active=%0b never rose", active);
    end
  endtask

  task automatic test_reset;
    compared++;
    if (fall_x !== 10'd1023 || fall_y !== 10'd0 || fall_color !== 2'd0 || active !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_block: x=%0d y=%0d c=%0d a=%0b expected 1023 0 0 0", fall_x, fall_y, fall_color, active);
    end
    compared++;
    if (score !== 8'd0 || misses !== 2'd0 || game_over !== 1'b0 || win !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_game: score=%0d misses=%0d go=%0b win=%0b expected all 0", score, misses, game_over, win);
    end
    rst = 1'b0;
    repeat (7) @(negedge clk);
    compared++;
    if (active !== 1'b0) begin
      mismatched++;
      $display("FAIL spawn_early: active=%0b expected 0 after 7 clk", active);
    end
    @(negedge clk);
    compared++;
    if (active !== 1'b1 || fall_y !== 10'd0) begin
      mismatched++;
      $display("FAIL spawn: active=%0b y=%0d expected 1 0", active, fall_y);
    end
    compared++;
    if (fall_x !== exp_x(m_prev) || fall_color !== exp_c(m_prev) || fall_x > 10'd490 || fall_color == 2'd0) begin
      mismatched++;
      $display("FAIL spawn_pos: x=%0d c=%0d expected %0d %0d", fall_x, fall_color, exp_x(m_prev), exp_c(m_prev));
    end
  endtask

  task automatic test_fall;
    int e;
    for (int k = 1; k <= 5; k++) begin
      exp_y_q.push_back(k);
      repeat (3) @(negedge clk);
      compared++;
      if (fall_y !== 10'(k - 1)) begin
        mismatched++;
        $display("FAIL fall_hold: y=%0d expected %0d", fall_y, k - 1);
      end
      @(negedge clk);
      e = exp_y_q.pop_front();
      compared++;
      if (fall_y !== 10'(e)) begin
        mismatched++;
        $display("FAIL fall_step: y=%0d expected %0d", fall_y, e);
      end
    end
    pause = 1'b1;
    repeat (20) @(negedge clk);
    compared++;
    if (fall_y !== 10'd5) begin
      mismatched++;
      $display("FAIL pause_hold: y=%0d expected 5", fall_y);
    end
    pause = 1'b0;
    exp_y_q.push_back(6);
    repeat (3) @(negedge clk);
    compared++;
    if (fall_y !== 10'd5) begin
      mismatched++;
      $display("FAIL pause_phase: y=%0d expected 5", fall_y);
    end
    @(negedge clk);
    e = exp_y_q.pop_front();
    compared++;
    if (fall_y !== 10'(e)) begin
      mismatched++;
      $display("FAIL pause_resume: y=%0d expected %0d", fall_y, e);
    end
  endtask

  task automatic test_catch;
    wait_y(380, 2000);
    collision = 1'b1;
    @(negedge clk);
    compared++;
    if (active !== 1'b0 || fall_x !== 10'd1023 || score !== 8'd1) begin
      mismatched++;
      $display("FAIL catch: a=%0b x=%0d score=%0d expected 0 1023 1", active, fall_x, score);
    end
    @(negedge clk);
    collision = 1'b0;
    compared++;
    if (score !== 8'd1) begin
      mismatched++;
      $display("FAIL catch_trailing: score=%0d expected 1", score);
    end
    repeat (5) @(negedge clk);
    compared++;
    if (active !== 1'b0) begin
      mismatched++;
      $display("FAIL respawn_early: active=%0b expected 0", active);
    end
    @(negedge clk);
    compared++;
    if (active !== 1'b1 || fall_x !== exp_x(m_prev) || fall_color !== exp_c(m_prev)) begin
      mismatched++;
      $display("FAIL respawn: a=%0b x=%0d c=%0d expected 1 %0d %0d", active, fall_x, fall_color, exp_x(m_prev), exp_c(m_prev));
    end
  endtask

  task automatic test_tick_collision;
    wait_y(479, 2500);
    repeat (3) @(negedge clk);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    compared++;
    if (score !== 8'd2 || misses !== 2'd0 || active !== 1'b0) begin
      mismatched++;
      $display("FAIL tick_collision: score=%0d misses=%0d a=%0b expected 2 0 0", score, misses, active);
    end
  endtask

  task automatic test_miss;
    int seen;
    for (int m = 1; m <= 3; m++) begin
      wait_active(50);
      wait_y(479, 2500);
      repeat (3) @(negedge clk);
      compared++;
      if (active !== 1'b1 || misses !== 2'(m - 1)) begin
        mismatched++;
        $display("FAIL miss_early: a=%0b misses=%0d expected 1 %0d", active, misses, m - 1);
      end
      @(negedge clk);
      compared++;
      if (misses !== 2'(m) || active !== 1'b0 || fall_x !== 10'd1023 || fall_y !== 10'd479) begin
        mismatched++;
        $display("FAIL miss: misses=%0d a=%0b x=%0d y=%0d expected %0d 0 1023 479", misses, active, fall_x, fall_y, m);
      end
      compared++;
      if (game_over !== (m == 3) || win !== 1'b0) begin
        mismatched++;
        $display("FAIL miss_game_over: go=%0b win=%0b expected %0b 0", game_over, win, m == 3);
      end
    end
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (active !== 1'b0 || fall_x !== 10'd1023) seen++;
    end
    compared++;
    if (seen != 0 || score !== 8'd2 || game_over !== 1'b1) begin
      mismatched++;
      $display("FAIL done_idle: live_cycles=%0d score=%0d go=%0b expected 0 2 1", seen, score, game_over);
    end
  endtask

  task automatic test_win;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (game_over !== 1'b0 || misses !== 2'd0 || score !== 8'd0) begin
      mismatched++;
      $display("FAIL async_rst_game: go=%0b misses=%0d score=%0d expected 0 0 0", game_over, misses, score);
    end
    @(negedge clk);
    rst = 1'b0;
    height = 10'd15;
    repeat (8) @(negedge clk);
    compared++;
    if (active !== 1'b1 || win !== 1'b0 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL height15: a=%0b win=%0b go=%0b expected 1 0 0", active, win, game_over);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (fall_x !== 10'd1023 || active !== 1'b0 || fall_y !== 10'd0) begin
      mismatched++;
      $display("FAIL rst_mid_fall: x=%0d a=%0b y=%0d expected 1023 0 0", fall_x, active, fall_y);
    end
    @(negedge clk);
    rst = 1'b0;
    height = 10'd16;
    @(negedge clk);
    compared++;
    if (game_over !== 1'b1 || win !== 1'b1 || fall_x !== 10'd1023 || active !== 1'b0) begin
      mismatched++;
      $display("FAIL win: go=%0b win=%0b x=%0d a=%0b expected 1 1 1023 0", game_over, win, fall_x, active);
    end
    repeat (20) @(negedge clk);
    compared++;
    if (active !== 1'b0 || win !== 1'b1) begin
      mismatched++;
      $display("FAIL win_hold: a=%0b win=%0b expected 0 1", active, win);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (game_over !== 1'b0 || win !== 1'b0 || score !== 8'd0 || misses !== 2'd0 ||
        fall_x !== 10'd1023 || fall_y !== 10'd0 || fall_color !== 2'd0 || active !== 1'b0) begin
      mismatched++;
      $display("FAIL final_rst: go=%0b win=%0b score=%0d misses=%0d x=%0d y=%0d c=%0d a=%0b expected reset values",
               game_over, win, score, misses, fall_x, fall_y, fall_color, active);
    end
    @(negedge clk);
    rst = 1'b0;
    height = 10'd0;
  endtask

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    collision = 1'b0;
    height = 10'd0;
    repeat (2) @(negedge clk);
    test_reset;
    test_fall;
    test_catch;
    test_tick_collision;
    test_miss;
    test_win;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
